// File: rtl/calc_pkg.sv
// Shared opcode and state encodings for the calculator execute stage.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_DIV = 3'b110,
        OP_RSV = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic overflow;
        logic div_zero;
        logic bad_op;
    } calc_flags_t;

    // Ops that need the bit-serial datapath; divide-by-zero resolves in one cycle.
    function automatic logic is_iterative(input opcode_t op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// Bit-serial unsigned multiplier / restoring divider sharing one accumulator and shift register.
module calc_muldiv_iter
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_mode,
    output logic             last_c,
    output logic [WIDTH-1:0] acc_c,
    output logic [WIDTH-1:0] shreg_c
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    assign last_c = (cnt_q == CW'(WIDTH - 1));

    // MUL: acc:shreg holds the partial product; DIV: acc is the remainder, shreg the quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, shreg_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_c     = mul_sum[WIDTH:1];
        shreg_c   = {mul_sum[0], shreg_q[WIDTH-1:1]};
        if (div_mode) begin
            acc_c   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            shreg_c = {shreg_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            shreg_q  <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc_q    <= '0;
            shreg_q  <= a;
            opnd_q   <= b;
            cnt_q    <= '0;
            div_mode <= is_div;
        end else if (step) begin
            acc_q    <= acc_c;
            shreg_q  <= shreg_c;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/calc_exec_unit.sv
// Execute stage: single-cycle ALU ops plus start/busy/done sequencing of the iterative MUL/DIV.
module calc_exec_unit
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_zero,
    output logic             bad_op
);

    state_t           state_q, state_d;
    calc_flags_t      flags_q, flags_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] result_d, remainder_d;
    logic             iter_load, iter_step;
    logic             iter_div_mode, iter_last_c;
    logic [WIDTH-1:0] iter_acc_c, iter_shreg_c;
    logic [WIDTH-1:0] add_c, sub_c;
    logic             add_ovf_c, sub_ovf_c, b_zero_c;
    opcode_t          opc;

    assign opc       = opcode_t'(op);
    assign b_zero_c  = (operandB == '0);
    assign add_c     = operandA + operandB;
    assign sub_c     = operandA - operandB;
    assign add_ovf_c = (operandA[WIDTH-1] == operandB[WIDTH-1]) && (add_c[WIDTH-1] != operandA[WIDTH-1]);
    assign sub_ovf_c = (operandA[WIDTH-1] != operandB[WIDTH-1]) && (sub_c[WIDTH-1] != operandA[WIDTH-1]);

    assign overflow = flags_q.overflow;
    assign div_zero = flags_q.div_zero;
    assign bad_op   = flags_q.bad_op;

    calc_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (iter_load),
        .step     (iter_step),
        .is_div   (opc == OP_DIV),
        .a        (operandA),
        .b        (operandB),
        .div_mode (iter_div_mode),
        .last_c   (iter_last_c),
        .acc_c    (iter_acc_c),
        .shreg_c  (iter_shreg_c)
    );

    // Next state and next output values; result holds until an op completes.
    always_comb begin
        state_d     = state_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        result_d    = result;
        remainder_d = remainder;
        flags_d     = flags_q;
        iter_load   = 1'b0;
        iter_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    flags_d     = '0;
                    remainder_d = '0;
                    if (is_iterative(opc, b_zero_c)) begin
                        state_d   = CALC;
                        busy_d    = 1'b1;
                        iter_load = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        case (opc)
                            OP_ADD: begin
                                result_d         = add_c;
                                flags_d.overflow = add_ovf_c;
                            end
                            OP_SUB: begin
                                result_d         = sub_c;
                                flags_d.overflow = sub_ovf_c;
                            end
                            OP_AND: result_d = operandA & operandB;
                            OP_OR:  result_d = operandA | operandB;
                            OP_XOR: result_d = operandA ^ operandB;
                            OP_DIV: begin
                                result_d         = '1;
                                remainder_d      = operandA;
                                flags_d.div_zero = 1'b1;
                            end
                            default: begin
                                result_d       = '0;
                                flags_d.bad_op = 1'b1;
                            end
                        endcase
                    end
                end
            end
            CALC: begin
                iter_step = 1'b1;
                busy_d    = 1'b1;
                if (iter_last_c) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = iter_shreg_c;
                    if (iter_div_mode) begin
                        remainder_d = iter_acc_c;
                    end else begin
                        flags_d.overflow = |iter_acc_c;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            result    <= result_d;
            remainder <= remainder_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: tb/tb_calc_exec_unit.sv
// Directed scoreboard bench for calc_exec_unit (WIDTH=32).
module tb_calc_exec_unit;
    import calc_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] operandA, operandB;
    logic [2:0]   op;
    logic         start;
    logic         busy, done, overflow, div_zero, bad_op;
    logic [W-1:0] result, remainder;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         ovf;
        logic         dz;
        logic         bad;
        logic [7:0]   lat;
        logic [7:0]   bsy;
    } exp_t;

    exp_t        sb[$];
    int unsigned passed = 0;
    int unsigned total  = 0;

    calc_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .operandA  (operandA),
        .operandB  (operandB),
        .op        (op),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .bad_op    (bad_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour built from plain arithmetic operators.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] s;
        logic [63:0]  p;
        e     = '0;
        e.lat = 8'd1;
        case (o)
            OP_ADD: begin s = a + b; e.res = s; e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
            OP_SUB: begin s = a - b; e.res = s; e.ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_XOR: e.res = a ^ b;
            OP_MUL: begin
                p     = 64'(a) * 64'(b);
                e.res = p[31:0];
                e.ovf = (p[63:32] != 32'd0);
                e.lat = 8'(W + 1);
                e.bsy = 8'(W);
            end
            OP_DIV: begin
                if (b == '0) begin
                    e.res = '1;
                    e.rem = a;
                    e.dz  = 1'b1;
                end else begin
                    e.res = a / b;
                    e.rem = a % b;
                    e.lat = 8'(W + 1);
                    e.bsy = 8'(W);
                end
            end
            default: e.bad = 1'b1;
        endcase
        return e;
    endfunction

    // Called one negedge after the start edge; optionally pokes an ADD start at cycle disturb_cyc.
    task automatic wait_done(input string tag, input int disturb_cyc);
        int   cyc  = 1;
        int   bcnt = 0;
        exp_t e;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) bcnt++;
            if (cyc == disturb_cyc) begin
                start    = 1'b1;
                op       = OP_ADD;
                operandA = 32'h0000_0055;
            end else if (cyc == disturb_cyc + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        chk({tag, ".latency"}, 64'(cyc), 64'(e.lat));
        chk({tag, ".busy_cycles"}, 64'(bcnt), 64'(e.bsy));
        chk({tag, ".result"}, 64'(result), 64'(e.res));
        chk({tag, ".remainder"}, 64'(remainder), 64'(e.rem));
        chk({tag, ".overflow"}, 64'(overflow), 64'(e.ovf));
        chk({tag, ".div_zero"}, 64'(div_zero), 64'(e.dz));
        chk({tag, ".bad_op"}, 64'(bad_op), 64'(e.bad));
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, ".result_hold"}, 64'(result), 64'(e.res));
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int disturb_cyc);
        sb.push_back(model(o, a, b));
        op       = o;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, disturb_cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".result"}, 64'(result), 64'd0);
        chk({tag, ".remainder"}, 64'(remainder), 64'd0);
        chk({tag, ".flags"}, 64'({overflow, div_zero, bad_op}), 64'd0);
    endtask

    initial begin
        int   dcnt;
        exp_t e;
        rst      = 1'b1;
        start    = 1'b0;
        op       = OP_ADD;
        operandA = '0;
        operandB = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, -10);
        chk("add_ovf.const", 64'(result), 64'h8000_0000);
        run_op("sub", OP_SUB, 32'd5, 32'd7, -10);
        chk("sub.const", 64'(result), 64'hFFFF_FFFE);
        run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, -10);
        run_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, -10);
        run_op("or", OP_OR, 32'hF000_0001, 32'h0000_0F00, -10);

        run_op("mul_hi", OP_MUL, 32'h0001_0000, 32'h0001_0000, -10);
        chk("mul_hi.ovf_const", 64'(overflow), 64'd1);
        run_op("mul_small", OP_MUL, 32'd1234, 32'd5678, -10);
        chk("mul_small.const", 64'(result), 64'd7006652);
        run_op("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10);

        run_op("div", OP_DIV, 32'd100, 32'd7, -10);
        chk("div.const", 64'({result, remainder}), {32'd14, 32'd2});
        run_op("div_zero", OP_DIV, 32'd9, 32'd0, -10);
        run_op("flag_clear", OP_ADD, 32'd1, 32'd1, -10);
        run_op("div_small", OP_DIV, 32'd5, 32'd10, -10);
        run_op("div_max", OP_DIV, 32'hFFFF_FFFF, 32'd1, -10);

        // Start pulse and operand change mid-DIV must be ignored.
        run_op("div_ignore", OP_DIV, 32'd100, 32'd7, 10);
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("div_ignore.no_extra_done", 64'(dcnt), 64'd0);

        // Start asserted during the DONE cycle is dropped.
        e        = model(OP_ADD, 32'd20, 32'd22);
        op       = OP_ADD;
        operandA = 32'd20;
        operandB = 32'd22;
        start    = 1'b1;
        @(negedge clk);
        chk("done_start.done", 64'(done), 64'd1);
        op       = OP_SUB;
        operandA = 32'd9;
        operandB = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("done_start.no_done1", 64'(done), 64'd0);
        @(negedge clk);
        chk("done_start.no_done2", 64'(done), 64'd0);
        chk("done_start.result", 64'(result), 64'(e.res));

        // Reset in the middle of a multiply.
        op       = OP_MUL;
        operandA = 32'd77;
        operandB = 32'd99;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("rst_mid.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("rst_mid.no_done", 64'(dcnt), 64'd0);
        run_op("post_rst_add", OP_ADD, 32'd2, 32'd3, -10);
        chk("post_rst_add.const", 64'(result), 64'd5);

        // Held start re-issues every time IDLE is re-entered.
        op       = OP_XOR;
        operandA = 32'hF0F0_F0F0;
        operandB = 32'hFFFF_FFFF;
        start    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("held_xor.done_c%0d", i), 64'(done), 64'(i % 2));
            if (i % 2 == 1) chk($sformatf("held_xor.result_c%0d", i), 64'(result), 64'h0F0F_0F0F);
        end
        start = 1'b0;
        @(negedge clk);
        chk("held_xor.stopped", 64'(done), 64'd0);

        run_op("bad_op", OP_RSV, 32'h1234_5678, 32'h9ABC_DEF0, -10);
        chk("bad_op.const", 64'({bad_op, result}), {31'd0, 1'b1, 32'd0});
        run_op("bad_op_clear", OP_XOR, 32'hAAAA_0000, 32'h5555_0000, -10);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calc_exec_unit.md
Name: calc_exec_unit

Overview:
- Execute stage directly downstream of the operand selector. Consumes operandA/operandB (register, switch or RAM-sourced) and an opcode, and produces a registered result for display or RAM writeback.
- Simple ops complete in 1 cycle. Unsigned multiply and divide run iteratively, one bit per cycle, behind a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; sets the iteration count for MUL/DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- operandA  input  WIDTH  first operand, from the operand selector.
- operandB  input  WIDTH  second operand, from the operand selector.
- op  input  3  opcode; encoding in calc_pkg.
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high while an operation is in flight (CALC state).
- done  output  1  one-cycle pulse when result/remainder/flags are valid.
- result  output  WIDTH  sum/difference/logic result, low product word, or quotient.
- remainder  output  WIDTH  DIV remainder; 0 for every other op.
- overflow  output  1  ADD/SUB signed overflow; MUL high product word nonzero.
- div_zero  output  1  DIV issued with operandB == 0.
- bad_op  output  1  reserved opcode issued.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy=0, done=0, result=0, remainder=0, overflow=0, div_zero=0, bad_op=0. Iteration counter=0.
- States: IDLE, CALC, DONE.
- Operand latching: operandA, operandB and op are captured on the edge where start=1 in IDLE. Later input changes do not affect the operation in flight.
- IDLE to DONE (1-cycle ops): ADD, SUB, AND, OR, XOR, reserved, and DIV-by-zero. Outputs are registered on the start edge, and done=1 in the following cycle.
- IDLE to CALC: MUL, and DIV with operandB != 0. busy=1 from the next cycle.
- CALC: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, for exactly WIDTH cycles. After the last step, go to DONE with outputs registered.
  - Latency from the start edge to the done-high cycle is WIDTH+1 cycles (33 for WIDTH=32).
- DONE: done=1 for exactly one cycle, then back to IDLE.
  - result and flags hold until the next accepted start. They are not cleared when done drops.
  - A start asserted during the DONE cycle is ignored.
- start in CALC or DONE: ignored. No queueing, no abort.
- Held start: a start held high in IDLE begins a new operation every time IDLE is re-entered.
- Arithmetic:
  - ADD/SUB: two's-complement, modulo 2^WIDTH. overflow = signed overflow (operand signs equal and differ from the result sign for ADD; operand signs differ and the result sign differs from A for SUB).
  - AND/OR/XOR: bitwise; overflow=0.
  - MUL: unsigned, 2*WIDTH-bit internal product. result = low word; overflow = (high word != 0).
  - DIV: unsigned. result = quotient, remainder = remainder.
  - DIV with B=0: result = all ones, remainder = A, div_zero=1, 1-cycle latency.
  - Reserved opcode: result=0, bad_op=1.
- Flag clearing: each accepted start clears all flags not set by the new operation.
- Reset mid-operation: immediately returns to IDLE with reset values. The in-flight result is lost and no done pulse is issued.

Decomposition:
- calc_pkg holds:
  - opcode constants: OP_ADD=3'b000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_MUL=101, OP_DIV=110, OP_RSV=111;
  - state encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
- Sub-module calc_muldiv_iter: the iterative datapath (accumulator, shift register, counter) with load/step/last signals. calc_exec_unit holds the FSM, the single-cycle ops and the flag registers.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, start 1 cycle -> done exactly 1 cycle later, result=0x80000000, overflow=1. SUB 5-7 -> result=0xFFFFFFFE, overflow=0.
- MUL 0x00010000*0x00010000 -> busy for 32 cycles, done 33 cycles after start, result=0, overflow=1. MUL 1234*5678 -> result=7006652, overflow=0.
- DIV 100/7 -> done at cycle 33, result=14, remainder=2. DIV 9/0 -> done after 1 cycle, result=0xFFFFFFFF, remainder=9, div_zero=1.
- Start DIV 100/7, then pulse start with op=ADD and change operandA at cycle 10 -> ignored; result=14 at cycle 33, no extra done pulse.
- Start MUL, assert rst at cycle 15 for 1 cycle -> all outputs 0 immediately, no done. Next ADD 2+3 -> result=5 after 1 cycle.
- Hold start high with op=XOR, A=0xF0F0F0F0, B=0xFFFFFFFF -> done pulses every 2 cycles, result=0x0F0F0F0F. Opcode 3'b111 -> bad_op=1, result=0.
